// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU types; instruction-cache address split, frame, FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ISETS_DEFAULT = 8;
  localparam int IIDX_W        = $clog2(ISETS_DEFAULT);
  localparam int ITAG_W        = 32 - 3 - IIDX_W;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t [1:0]       data;
  } icache_frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2
  } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_stats.sv
// ============================================================================
// Module   : icache_stats
// Purpose  : Saturating hit/miss counters; built only with ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_stats (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        hit_inc,
  input  logic        miss_inc,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit_inc && (hit_count_q != 32'hFFFF_FFFF)) hit_count_d = hit_count_q + 32'd1;
    if (miss_inc && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped two-word-block instruction cache with refill FSM.
//            Define ICACHE_STATS_EN to build the hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - 3 - IW;

  icache_state_t   state_q, state_d;
  logic [28:0]     base_q, base_d;     // block address, bits [31:3]
  word_t           word0_q, word0_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [TW-1:0]   tag_q   [SETS];
  logic [TW-1:0]   tag_d   [SETS];
  word_t           data0_q [SETS];
  word_t           data0_d [SETS];
  word_t           data1_q [SETS];
  word_t           data1_d [SETS];

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          req_blk;
  logic [1:0]    unused_bytoff;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          miss_start;

  assign req_idx       = imemaddr[2+IW:3];
  assign req_tag       = imemaddr[31:3+IW];
  assign req_blk       = imemaddr[2];
  assign unused_bytoff = imemaddr[1:0];
  assign fill_idx      = base_q[IW-1:0];
  assign fill_tag      = base_q[28:IW];

  assign ihit = (state_q == IDLE) && imemREN && valid_q[req_idx]
             && (tag_q[req_idx] == req_tag);
  assign imemload   = ihit ? (req_blk ? data1_q[req_idx] : data0_q[req_idx]) : '0;
  assign miss_start = (state_q == IDLE) && imemREN && !ihit;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    word0_d = word0_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data0_d = data0_q;
    data1_d = data1_q;
    iREN    = 1'b0;
    iaddr   = '0;
    case (state_q)
      IDLE: begin
        if (miss_start) begin
          base_d  = imemaddr[31:3];
          state_d = FETCH0;
        end
      end
      FETCH0: begin
        iREN  = 1'b1;
        iaddr = {base_q, 3'b000};
        if (!iwait) begin
          word0_d = iload;
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        iREN  = 1'b1;
        iaddr = {base_q, 3'b100};
        if (!iwait) begin
          valid_d[fill_idx] = 1'b1;
          tag_d[fill_idx]   = fill_tag;
          data0_d[fill_idx] = word0_q;
          data1_d[fill_idx] = iload;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over a completing fill and abandons any refill in flight.
    if (iflush) begin
      valid_d = '0;
      if (state_q != IDLE) state_d = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= IDLE;
      base_q  <= '0;
      word0_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word0_q <= word0_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag_q   <= tag_d;
    data0_q <= data0_d;
    data1_q <= data1_d;
  end

`ifdef ICACHE_STATS_EN
  icache_stats u_stats (
    .CLK        (CLK),
    .nRST       (nRST),
    .hit_inc    (ihit),
    .miss_inc   (miss_start),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module   : tb_icache
// Purpose  : Randomised scoreboard bench for icache against a set/tag model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST, imemREN, iflush, iwait, ihit, iREN;
  logic [31:0] imemaddr, imemload, iaddr, iload, hit_count, miss_count;

  icache #(.SETS(8)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iflush     (iflush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
    bit          chk_lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] addr_q[$];
  int compared = 0, mismatched = 0;
  int cyc = 0, req_cyc = 0, wait_cnt = 0, wait_mode = 0, fix_cnt = 0;
  bit abort = 0;

  // Reference model: one (valid, tag) pair per set, tag = addr[31:6].
  bit          m_valid [8];
  logic [25:0] m_tag   [8];
  int m_hits = 0, m_misses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:3] == 29'd0) return a[2] ? 32'h3C00_0002 : 32'h3C00_0001;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    logic [31:0] eh, em;
`ifdef ICACHE_STATS_EN
    eh = m_hits;
    em = m_misses;
`else
    eh = 0;
    em = 0;
`endif
    check({tag, "_hit_count"}, hit_count, eh);
    check({tag, "_miss_count"}, miss_count, em);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
  endtask

  task automatic wait_hit();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      got = ihit;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL fetch_timeout: no ihit for addr %h within 200 cycles", imemaddr);
      abort = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  // Called one time unit after a rising edge; returns likewise.
  task automatic do_fetch(input logic [31:0] a);
    exp_t e;
    int   idx;
    bit   hit;
    if (abort) return;
    idx = int'(a[5:3]);
    hit = m_valid[idx] && (m_tag[idx] == a[31:6]);
    if (!hit) begin
      addr_q.push_back({a[31:3], 3'b000});
      addr_q.push_back({a[31:3], 3'b100});
      m_valid[idx] = 1;
      m_tag[idx]   = a[31:6];
      m_misses++;
    end
    m_hits++;
    e.addr = a; e.data = mem_word(a); e.miss = !hit; e.chk_lat = 1;
    sb_q.push_back(e);
    imemaddr = a;
    imemREN  = 1'b1;
    wait_cnt = 0;
    req_cyc  = cyc;
    wait_hit();
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Memory responder: drives iwait/iload and checks each accepted read address.
  initial begin
    iwait = 1'b0;
    iload = '0;
    forever begin
      @(negedge CLK);
      if (iREN) begin
        case (wait_mode)
          0:       iwait = 1'b0;
          1:       iwait = ($urandom_range(0, 2) == 0);
          default: begin
            if (fix_cnt < 3) begin iwait = 1'b1; fix_cnt++; end
            else iwait = 1'b0;
          end
        endcase
        iload = mem_word(iaddr);
        if (iwait) wait_cnt++;
        else begin
          fix_cnt = 0;
          if (addr_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_read: iaddr %h with no refill expected", iaddr);
          end else check("iaddr", iaddr, addr_q.pop_front());
        end
      end else begin
        iwait = 1'b0;
        iload = '0;
      end
    end
  end

  // Monitor: every ihit cycle consumes one scoreboard entry.
  initial forever begin
    @(negedge CLK);
    if (ihit) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_ihit: addr %h data %h", imemaddr, imemload);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hit_addr", imemaddr, e.addr);
        check("imemload", imemload, e.data);
        if (e.chk_lat) check("latency", cyc - req_cyc, e.miss ? 3 + wait_cnt : 0);
      end
    end else if (!nRST) begin
      check("imemload_nohit", imemload, 32'h0);
    end
  end

  initial begin
    exp_t e;
    nRST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b0;
    check("rst_ihit", ihit, 0);
    check("rst_imemload", imemload, 0);
    check("rst_iREN", iREN, 0);
    check("rst_iaddr", iaddr, 0);
    check_stats("rst");

    // Cold miss then same-block hit
    do_fetch(32'h0000_0000);
    do_fetch(32'h0000_0004);
    check_stats("cold");

    // Three wait states per word
    wait_mode = 2;
    do_fetch(32'h0000_0008);
    wait_mode = 0;
    check_stats("wait");

    // Conflict on set 0
    do_fetch(32'h0000_0000);
    do_fetch(32'h0000_0040);
    do_fetch(32'h0000_0000);
    check_stats("conflict");

    // Redirect during FETCH0: block 0x10 completes, then 0x80 refills
    if (!abort) begin
      addr_q.push_back(32'h10); addr_q.push_back(32'h14);
      addr_q.push_back(32'h80); addr_q.push_back(32'h84);
      m_valid[2] = 1; m_tag[2] = 26'd0;
      m_valid[0] = 1; m_tag[0] = 26'd2;
      m_misses += 2; m_hits++;
      e.addr = 32'h80; e.data = mem_word(32'h80); e.miss = 1; e.chk_lat = 0;
      sb_q.push_back(e);
      imemaddr = 32'h10; imemREN = 1'b1;
      @(posedge CLK); #1;
      check("redir_iREN", iREN, 1);
      check("redir_iaddr", iaddr, 32'h10);
      imemaddr = 32'h80;
      wait_hit();
      check_stats("redirect");
    end

    // Flush in FETCH1 after 0x00 is resident
    do_fetch(32'h0000_0000);
    do_fetch(32'h0000_0000);
    if (!abort) begin
      addr_q.push_back(32'h20); addr_q.push_back(32'h24);
      m_misses++;
      imemaddr = 32'h20; imemREN = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("flush_fetch1_iaddr", iaddr, 32'h24);
      iflush = 1'b1;
      @(posedge CLK); #1;
      iflush = 1'b0; imemREN = 1'b0;
      model_clear();
      check("flush_iREN", iREN, 0);
      @(posedge CLK); #1;
      check("flush_iREN_idle", iREN, 0);
    end
    do_fetch(32'h0000_0000);
    check_stats("flush");

    // Reset asserted in FETCH0
    if (!abort) begin
      addr_q.push_back(32'h40);
      imemaddr = 32'h40; imemREN = 1'b1;
      @(posedge CLK); #1;
      check("rstmid_iaddr", iaddr, 32'h40);
      nRST = 1'b1; imemaddr = 32'h0;
      @(posedge CLK); #1;
      nRST = 1'b0;
      model_clear();
      m_hits = 0; m_misses = 0;
      check("rstmid_ihit", ihit, 0);
      check("rstmid_imemload", imemload, 0);
      check("rstmid_iREN", iREN, 0);
      check("rstmid_iaddr0", iaddr, 0);
      check_stats("rstmid");
      imemREN = 1'b0;
      @(posedge CLK); #1;
    end

    // Randomised traffic with idle gaps and occasional flushes
    wait_mode = 1;
    for (int n = 0; n < 300 && !abort; n++) begin
      logic [31:0] a;
      a = {24'd0, 2'(($urandom_range(0, 3))), 3'(($urandom_range(0, 7))), 1'(($urandom_range(0, 1))), 2'b00};
      if ($urandom_range(0, 9) == 0) a = a | 32'hFFFF_FF00;
      do_fetch(a);
      if ($urandom_range(0, 3) == 0) begin
        imemREN  = 1'b0;
        imemaddr = {$urandom} & 32'hFFFF_FFFC;
        if ($urandom_range(0, 4) == 0) begin
          iflush = 1'b1;
          model_clear();
        end
        @(posedge CLK); #1;
        iflush = 1'b0;
      end
    end
    imemREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_stats("final");
    check("sb_drained", sb_q.size(), 0);
    check("reads_drained", addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, two-word-block instruction cache between the pipeline's fetch stage and the memory controller. Serves the fetch address each cycle, reporting a same-cycle hit. On a miss it fetches the full block over the instruction memory port through a small refill state machine and writes it into the frame array; the fetch stage stalls until the hit appears.

## Interface
- `SETS`, default 8: number of frames. Must be a power of two ≥ 2. Index width is `$clog2(SETS)`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `nRST` in 1: reset, synchronous, active-high.
- `imemREN` in 1: fetch request from the datapath.
- `imemaddr` in 32: fetch byte address, word-aligned.
- `ihit` out 1: requested word valid this cycle.
- `imemload` out 32: requested instruction; 0 when `ihit`=0.
- `iflush` in 1: invalidate all frames.
- `iREN` out 1: memory read request.
- `iaddr` out 32: memory word address.
- `iwait` in 1: memory not ready; `iload` valid when `iREN`=1 and `iwait`=0.
- `iload` in 32: memory read data.
- `hit_count` out 32: hit counter (see Configuration).
- `miss_count` out 32: miss counter (see Configuration).

## Operation
- Address split: [1:0] byte offset (ignored); [2] word in block; [2+IW:3] index; [31:3+IW] tag, where IW is the index width.
- Frame contents: valid bit, tag, word0, word1.
- `ihit` = IDLE && `imemREN` && valid[idx] && tag match.
- `imemload` = the frame word selected by bit [2] when `ihit`=1; otherwise 0.
- FSM states: IDLE, FETCH0, FETCH1.
- IDLE:
  - `iREN`=0 and `iaddr`=0.
  - On `imemREN` with a miss: latch the block base address {tag, idx, 3'b000} and go to FETCH0.
- FETCH0:
  - `iREN`=1, `iaddr`=base.
  - On `iwait`=0: capture `iload` as word0 and go to FETCH1.
- FETCH1:
  - `iREN`=1, `iaddr`=base+4.
  - On `iwait`=0: write the frame (valid=1, latched tag, word0, `iload` as word1) and go to IDLE.
- `imemaddr` changes during a refill (branch or jump redirect): ignored. The latched block completes and the new address is evaluated in IDLE.
- `imemREN` drops during a refill: the refill still completes.
- `iflush`:
  - Clears every valid bit in the same edge.
  - In FETCH0/FETCH1 it also aborts the refill: FSM goes to IDLE, no frame write, and `iREN`=0 from the next cycle.
  - `iflush` has priority over a simultaneous frame write.
- A refill overwrites the frame unconditionally; there is no write-back, since instructions are never dirty.

## Timing
- Reset values: all valid=0, FSM=IDLE, latched base=0, word0 buffer=0, counters=0. Hence `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- Hit latency is 0 cycles; `ihit` and `imemload` are combinational from `imemaddr`.
- Miss with zero-wait memory:
  - Miss seen in cycle N.
  - FETCH0 in N+1, FETCH1 in N+2.
  - `ihit` in N+3.
  - Each `iwait` cycle adds one cycle.
- `iREN` and `iaddr` are pure functions of the registered state and latched base; there is no combinational path from `imemaddr`.
- Reset asserted mid-refill: next cycle is IDLE with all frames invalid; a partial block is never written.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on every cycle with `ihit`=1, including repeat cycles while the pipeline is stalled.
  - `miss_count` increments on each IDLE→FETCH0 transition.
  - Both saturate at 32'hFFFFFFFF.
  - Both clear on reset only; `iflush` does not clear them.
- `ICACHE_STATS_EN` undefined: both ports remain and are tied to 0; no counter flops exist.

## Structure
- Shared package `cpu_types_pkg` gains:
  - `icachef_t`, a packed struct {tag, idx, blkoff, bytoff} sized for the default SETS.
  - `icache_frame_t` {valid, tag, word_t data[2]}.
  - `icache_state_t` enum {IDLE, FETCH0, FETCH1}.
  - Constants `IIDX_W` and `ITAG_W`.
- One sub-module, `icache_stats`: the two saturating counters and the increment logic. It is instantiated only under `ICACHE_STATS_EN`.

## Test plan
- Cold miss, zero-wait memory: reset, fetch 0x00000000 with memory 0x00:0x3C000001 and 0x04:0x3C000002.
  - Expect `iREN` at 0x00 then 0x04, and `ihit` 3 cycles after the request with `imemload`=0x3C000001.
  - Fetch 0x04 next: `ihit` in the same cycle with 0x3C000002.
- Wait states: `iwait` held 3 cycles per word → `ihit` 9 cycles after the miss. With stats enabled, `miss_count`=1.
- Conflict, SETS=8: fetch 0x00 then 0x40 (same index, different tag).
  - 0x40 misses and refills.
  - Re-fetching 0x00 misses again.
  - `miss_count`=3.
- Redirect mid-refill: change `imemaddr` 0x10→0x80 during FETCH0.
  - Block 0x10 completes.
  - The next cycle starts the refill of 0x80 (`iaddr`=0x80).
- Flush: `iflush` asserted in FETCH1.
  - No frame write, `iREN`=0 the next cycle.
  - The previously-hitting address 0x00 now misses.
- Reset mid-refill: assert `nRST` in FETCH0.
  - All outputs 0 the next cycle.
  - With stats enabled, `hit_count`=`miss_count`=0.
